// File: rtl/xor_frame_check.sv
// Frame checker: XORs the payload words of each frame and compares the result with the trailing check word.
// Each result is held on a valid/ready port until the consumer takes it.
module xor_frame_check #(
    parameter int WIDTH  = 8,
    parameter int MAXLEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ok,
    output logic [WIDTH-1:0] out_sum,
    output logic [7:0]       out_len
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [7:0] MAXLEN_W = 8'(MAXLEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;
    logic             r_ok;
    logic [WIDTH-1:0] r_sum;
    logic [7:0]       r_len;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [7:0]       w_cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments, so every process reads the pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                // rst_n gates in_ready so it falls as soon as reset asserts.
                in_ready = rst_n;
                if (w_in_fire) begin
                    w_state_nxt = in_last ? RESULT : ACC;
                end
            end
            ACC: begin
                in_ready = rst_n;
                if (w_in_fire && in_last) begin
                    w_state_nxt = RESULT;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_ok  <= 1'b0;
            r_sum <= '0;
            r_len <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        if (in_last) begin
                            r_sum <= '0;
                            r_len <= '0;
                            r_ok  <= (in_data == '0);
                        end else begin
                            r_acc <= in_data;
                            r_cnt <= 8'd1;
                            r_ovf <= (MAXLEN < 1);
                        end
                    end
                end
                ACC: begin
                    if (w_in_fire) begin
                        if (in_last) begin
                            r_sum <= r_acc;
                            r_len <= r_cnt;
                            r_ok  <= (r_acc == in_data) && !r_ovf;
                        end else begin
                            // The count keeps going after overflow so out_len reports the true length.
                            r_acc <= r_acc ^ in_data;
                            r_cnt <= w_cnt_inc;
                            r_ovf <= r_ovf | (r_cnt == MAXLEN_W);
                        end
                    end
                end
                RESULT: begin
                    if (w_out_fire) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_ok  = r_ok;
    assign out_sum = r_sum;
    assign out_len = r_len;

endmodule

// File: tb/tb_xor_frame_check.sv
// Directed bench for xor_frame_check: every expected value below is hand-computed.
module tb_xor_frame_check;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       out_ok;
    logic [7:0] out_sum;
    logic [7:0] out_len;

    int checks   = 0;
    int failures = 0;

    xor_frame_check #(.WIDTH(8), .MAXLEN(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ok   (out_ok),
        .out_sum  (out_sum),
        .out_len  (out_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one beat and returns 1 time unit after the edge that accepted it.
    task automatic beat(input logic [7:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            check("beat_accept_timeout", 8'd0, 8'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic ok, input logic [7:0] sum,
                                input logic [7:0] len);
        check({tag, "_valid"}, 8'(out_valid), 8'd1);
        check({tag, "_ok"},    8'(out_ok),    8'(ok));
        check({tag, "_sum"},   out_sum,       sum);
        check({tag, "_len"},   out_len,       len);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready",  8'(in_ready),  8'd0);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_ok",    8'(out_ok),    8'd0);
        check("rst_out_sum",   out_sum,       8'h00);
        check("rst_out_len",   out_len,       8'h00);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_in_ready", 8'(in_ready), 8'd1);

        // Good frame: F0 ^ FF = 0F
        beat(8'hF0, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h0F, 1'b1);
        check_result("good", 1'b1, 8'h0F, 8'd2);
        check("good_in_ready_low", 8'(in_ready), 8'd0);
        idle(1);
        check("good_valid_drop", 8'(out_valid), 8'd0);
        check("good_in_ready_back", 8'(in_ready), 8'd1);

        // Bad check word
        beat(8'hF0, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h10, 1'b1);
        check_result("bad", 1'b0, 8'h0F, 8'd2);
        idle(1);

        // Zero-length frames
        beat(8'h00, 1'b1);
        check_result("zero_ok", 1'b1, 8'h00, 8'd0);
        idle(1);
        beat(8'hAA, 1'b1);
        check_result("zero_bad", 1'b0, 8'h00, 8'd0);
        idle(1);

        // Overlength: 17 payload beats
        for (int i = 0; i < 17; i++) beat(8'h00, 1'b0);
        beat(8'h00, 1'b1);
        check_result("over17", 1'b0, 8'h00, 8'd17);
        idle(1);

        // Exactly MAXLEN payload beats
        for (int i = 0; i < 16; i++) beat(8'h00, 1'b0);
        beat(8'h00, 1'b1);
        check_result("len16", 1'b1, 8'h00, 8'd16);
        idle(1);

        // Backpressure: 12 ^ 34 = 26, result held while a new frame waits
        out_ready = 1'b0;
        beat(8'h12, 1'b0);
        beat(8'h34, 1'b0);
        beat(8'h26, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_result("hold", 1'b1, 8'h26, 8'd2);
            check("hold_in_ready", 8'(in_ready), 8'd0);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        check("bp_valid_drop",  8'(out_valid), 8'd0);
        check("bp_sum_kept",    out_sum,       8'h26);
        check("bp_in_ready",    8'(in_ready),  8'd1);
        idle(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_next", 1'b0, 8'h00, 8'd0);
        idle(1);

        // Idle gaps inside a frame
        beat(8'hF0, 1'b0);
        idle(3);
        beat(8'hFF, 1'b0);
        idle(3);
        beat(8'h0F, 1'b1);
        check_result("gaps", 1'b1, 8'h0F, 8'd2);
        idle(1);

        // Asynchronous reset mid-frame
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  8'(in_ready),  8'd0);
        check("mid_rst_out_valid", 8'(out_valid), 8'd0);
        check("mid_rst_out_sum",   out_sum,       8'h00);
        #1;
        rst_n = 1'b1;
        idle(1);
        beat(8'h55, 1'b0);
        beat(8'h55, 1'b0);
        beat(8'h00, 1'b1);
        check_result("after_rst", 1'b1, 8'h00, 8'd2);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_frame_check.md
Name: xor_frame_check

Overview:
- Sequential byte-stream checker that consumes the bytewise XOR stage's output stream.
- Accumulates the XOR of all payload words in a frame.
- Compares that accumulation against a trailing check word and reports pass/fail, the running sum and the payload length through a valid/ready result port.
- Sits directly downstream of the 8-bit XOR logic block in the lecture datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- MAXLEN, 16, maximum legal payload words per frame, not counting the check word. Legal range 1..254.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  payload or check word
- in_last  input  1  marks the check word (final beat of frame)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_ok  output  1  1 = check word equals XOR of payload and length is legal
- out_sum  output  WIDTH  XOR of all payload words (check word excluded)
- out_len  output  8  payload word count, saturating at 255

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n. All state registers clear immediately on rst_n=0, independent of clk.
- Reset values:
  - state=IDLE
  - acc=0, cnt=0, ovf=0
  - out_valid=0, out_ok=0, out_sum=0, out_len=0
  - in_ready=0 while rst_n=0; in_ready=1 from the first cycle after release.
- Beat transfer: a beat transfers when in_valid && in_ready at a rising edge. Result transfer: out_valid && out_ready at a rising edge.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Transfer with in_last=0: acc<=in_data, cnt<=1, ovf<=(MAXLEN<1), go to ACC.
    - Transfer with in_last=1 (zero-length frame): out_sum<=0, out_len<=0, out_ok<=(in_data==0), go to RESULT.
  - ACC: in_ready=1.
    - Transfer with in_last=0: acc<=acc^in_data, cnt<=sat255(cnt+1), ovf<=ovf|(cnt==MAXLEN).
    - Transfer with in_last=1: out_sum<=acc, out_len<=cnt, out_ok<=(acc==in_data)&&!ovf, go to RESULT.
    - in_valid=0: hold all state; idle gaps are allowed anywhere inside a frame.
  - RESULT: in_ready=0, out_valid=1.
    - out_ok, out_sum and out_len are registered and stay stable until transfer.
    - On out_ready=1: go to IDLE; clear acc, cnt and ovf.
    - out_valid deasserts the cycle after transfer. out_ok/out_sum/out_len keep their last values while out_valid=0.
- Latency and throughput:
  - out_valid rises on the clock edge that accepts the in_last beat; it is visible the following cycle.
  - With out_ready held high, RESULT lasts exactly 1 cycle.
  - Minimum frame-to-frame gap is 1 cycle, during which in_ready=0.
- Overlength frames: once ovf is set the frame is still consumed until in_last, with accumulation continuing. Reported out_ok=0; out_len is the true count saturated at 255.
- Input values: in_data containing X/Z is not qualified; out_ok is undefined for that frame, and the block recovers on the next frame.
- Reset mid-frame or mid-RESULT: the partial frame and any pending result are discarded. The next accepted beat starts a fresh frame in IDLE.
- Inputs while in_ready=0: in_valid, in_data and in_last are ignored.

Test Plan:
- Good frame: payload 0xF0, 0xFF, then check 0x0F with in_last=1; out_ready=1 -> one cycle after the check beat, out_valid=1, out_ok=1, out_sum=0x0F, out_len=2.
- Bad check: same payload, check 0x10 -> out_ok=0, out_sum=0x0F, out_len=2. Zero-length frames: single beat 0x00 with in_last=1 -> out_ok=1, out_len=0; single beat 0xAA -> out_ok=0.
- Overlength (MAXLEN=16): 17 payload beats of 0x00, then check 0x00 -> out_ok=0, out_len=17, out_sum=0x00. Exactly 16 beats of 0x00 plus check 0x00 -> out_ok=1, out_len=16.
- Backpressure and gaps:
  - Hold out_ready=0 for 5 cycles after a result -> out_valid, out_ok, out_sum and out_len stay constant; in_ready=0 throughout.
  - A new frame offered meanwhile is not accepted until 1 cycle after out_ready=1.
  - in_valid gaps of 3 cycles inside a frame -> same result as the gap-free frame.
- Reset mid-frame: accept 0x33, 0x44, pulse rst_n low asynchronously between edges -> in_ready drops and out_valid=0 immediately. Then frame 0x55, 0x55, check 0x00 -> out_ok=1, out_sum=0x00, out_len=2, with no carry-over.
